// File: rtl/dly_line_prog_pkg.sv
// ============================================================================
// dly_line_prog_pkg : shared types, defaults and helpers for dly_line_prog.
// Revision: 1.0 - initial release
// ============================================================================
`include "dly_defines.vh"
`default_nettype none

package dly_line_prog_pkg;

    localparam int C_DEF_DLY = `DLY_DEF_DLY;
    localparam int C_MAX_DLY = `DLY_MAX_DLY;

    typedef enum logic {
        ST_FILL = `DLY_ST_FILL,
        ST_RUN  = `DLY_ST_RUN
    } ch_state_e;

    // Index width that never collapses to zero for a single channel.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dly_ch_slice.sv
// ============================================================================
// dly_ch_slice : one delay channel - free-running shift register, tap mux,
//                programmed delay and fill-tracking FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dly_ch_slice
    import dly_line_prog_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int MAX_DLY = 8,
    parameter int DEF_DLY = 4,
    parameter int DLY_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_cfg_we,
    input  logic [DLY_W-1:0] i_cfg_dly,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_vld
);

    localparam logic [DLY_W-1:0] C_DEF    = DLY_W'(DEF_DLY);
    localparam logic [DLY_W-1:0] C_MAX    = DLY_W'(MAX_DLY);
    localparam ch_state_e        C_RST_ST = (DEF_DLY <= 1) ? ST_RUN : ST_FILL;

    logic [WIDTH-1:0] r_stg [1:MAX_DLY];
    logic [DLY_W-1:0] r_dly;
    logic [DLY_W-1:0] r_cnt;
    logic [DLY_W-1:0] w_cnt_nxt;
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= MAX_DLY; k++) begin
                r_stg[k] <= '0;
            end
        end else begin
            r_stg[1] <= i_din;
            for (int k = 2; k <= MAX_DLY; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly   <= C_DEF;
            r_cnt   <= '0;
            r_state <= C_RST_ST;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            if (i_cfg_we) begin
                r_dly <= i_cfg_dly;
            end
        end
    end

    // The flag must already be high in the (dly)th cycle after the restart,
    // so the FSM leaves FILL one count before the counter reaches dly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_cfg_we) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (i_cfg_dly <= DLY_W'(1)) ? ST_RUN : ST_FILL;
        end else if (r_state == ST_FILL) begin
            if (r_cnt != C_MAX) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            if (({1'b0, r_cnt} + (DLY_W+1)'(2)) == {1'b0, r_dly}) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_comb begin
        o_dout = i_din;
        for (int k = 1; k <= MAX_DLY; k++) begin
            if (r_dly == DLY_W'(k)) begin
                o_dout = r_stg[k];
            end
        end
    end

    assign o_vld = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: rtl/dly_defines.vh
// ============================================================================
// dly_defines.vh : shared defaults and channel FSM state encodings for the
//                  programmable delay line.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef DLY_DEFINES_VH
`define DLY_DEFINES_VH

`define DLY_DEF_DLY 4
`define DLY_MAX_DLY 8
`define DLY_ST_FILL 1'b0
`define DLY_ST_RUN  1'b1

`endif

// File: rtl/dly_line_prog.sv
// ============================================================================
// dly_line_prog : multi-channel programmable delay line with a valid/ready
//                 config port for per-channel delay selection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dly_line_prog
    import dly_line_prog_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 1,
    parameter int MAX_DLY = C_MAX_DLY,
    parameter int DEF_DLY = C_DEF_DLY,
    localparam int CH_W   = clog2_min1(NUM_CH),
    localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH*WIDTH-1:0] dly_i,
    output logic [NUM_CH*WIDTH-1:0] dly_o,
    output logic [NUM_CH-1:0]       dly_vld_o,
    input  logic                    cfg_vld_i,
    output logic                    cfg_rdy_o,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [DLY_W-1:0]        cfg_dly_i,
    output logic                    cfg_err_o
);

    localparam logic [CH_W:0]    C_NUM_CH = (CH_W+1)'(NUM_CH);
    localparam logic [DLY_W-1:0] C_MAX    = DLY_W'(MAX_DLY);

    logic              r_rdy;
    logic              r_err;
    logic              w_xfer;
    logic              w_legal;
    logic [NUM_CH-1:0] w_we;

    assign w_xfer  = cfg_vld_i && r_rdy;
    assign w_legal = ({1'b0, cfg_ch_i} < C_NUM_CH) && (cfg_dly_i <= C_MAX);

    // Ready drops for one cycle after every transfer, legal or not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_rdy <= !w_xfer;
            r_err <= w_xfer && !w_legal;
        end
    end

    assign cfg_rdy_o = r_rdy;
    assign cfg_err_o = r_err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_we[c] = w_xfer && w_legal && (cfg_ch_i == CH_W'(c));

        dly_ch_slice #(
            .WIDTH   (WIDTH),
            .MAX_DLY (MAX_DLY),
            .DEF_DLY (DEF_DLY),
            .DLY_W   (DLY_W)
        ) u_slice (
            .clk       (clk_i),
            .rst       (rst_i),
            .i_din     (dly_i[c*WIDTH +: WIDTH]),
            .i_cfg_we  (w_we[c]),
            .i_cfg_dly (cfg_dly_i),
            .o_dout    (dly_o[c*WIDTH +: WIDTH]),
            .o_vld     (dly_vld_o[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_dly_line_prog.sv
// ============================================================================
// tb_dly_line_prog : self-checking bench for dly_line_prog (4 channels plus a
//                    3-channel instance for out-of-range channel requests).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dly_line_prog;

    localparam int NCH  = 4;
    localparam int MAXD = 8;
    localparam int DEFD = 4;
    localparam int NCYC = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       cfg_vld;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_dly;
    logic [3:0] dout, vld;
    logic       rdy, err;
    logic [2:0] dout3, vld3;
    logic       rdy3, err3;

    always #5 clk = ~clk;

    dly_line_prog #(.NUM_CH(4), .WIDTH(1), .MAX_DLY(8), .DEF_DLY(4)) dut (
        .clk_i(clk), .rst_i(rst), .dly_i(din), .dly_o(dout), .dly_vld_o(vld),
        .cfg_vld_i(cfg_vld), .cfg_rdy_o(rdy), .cfg_ch_i(cfg_ch),
        .cfg_dly_i(cfg_dly), .cfg_err_o(err)
    );

    dly_line_prog #(.NUM_CH(3), .WIDTH(1), .MAX_DLY(8), .DEF_DLY(4)) dut3 (
        .clk_i(clk), .rst_i(rst), .dly_i(din[2:0]), .dly_o(dout3), .dly_vld_o(vld3),
        .cfg_vld_i(cfg_vld), .cfg_rdy_o(rdy3), .cfg_ch_i(cfg_ch),
        .cfg_dly_i(cfg_dly), .cfg_err_o(err3)
    );

    // Reference model: input history per cycle, current delay and the cycle
    // in which each channel last restarted.
    int   t = 0;
    logic hist [NCH][NCYC];
    int   m_dly [NCH];
    int   m_start [NCH];
    int   m_rst_cyc = 0;
    logic m_rdy = 1'b0, m_err = 1'b0, m_err3 = 1'b0;
    int   checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic logic exp_out(input int c);
        int d = m_dly[c];
        if (d == 0) return din[c];
        if (t - d > m_rst_cyc) return hist[c][t-d];
        return 1'b0;
    endfunction

    function automatic logic exp_vld(input int c);
        return (m_dly[c] == 0) || (t >= m_start[c] + m_dly[c] - 1);
    endfunction

    task automatic do_cycle(input logic r, input logic v, input logic [1:0] ch,
                            input logic [3:0] dl, input logic [3:0] di);
        logic [3:0] eo, ev;
        logic       xfer, legal;
        @(negedge clk);
        rst = r; cfg_vld = v; cfg_ch = ch; cfg_dly = dl; din = di;
        #1;
        if (t > 0) begin
            for (int c = 0; c < NCH; c++) begin
                eo[c] = exp_out(c);
                ev[c] = exp_vld(c);
            end
            check("dly_o", dout, eo);
            check("dly_vld_o", vld, ev);
            check("cfg_rdy_o", rdy, m_rdy);
            check("cfg_err_o", err, m_err);
            check("dly_o_3ch", dout3, eo[2:0]);
            check("dly_vld_o_3ch", vld3, ev[2:0]);
            check("cfg_rdy_o_3ch", rdy3, m_rdy);
            check("cfg_err_o_3ch", err3, m_err3);
        end
        for (int c = 0; c < NCH; c++) hist[c][t] = di[c];
        if (r) begin
            m_rdy = 1'b0; m_err = 1'b0; m_err3 = 1'b0; m_rst_cyc = t;
            for (int c = 0; c < NCH; c++) begin
                m_dly[c] = DEFD; m_start[c] = t + 1;
            end
        end else begin
            xfer   = v && m_rdy;
            legal  = (int'(dl) <= MAXD);
            m_err  = xfer && !legal;
            m_err3 = xfer && !(legal && ch < 2'd3);
            m_rdy  = !xfer;
            if (xfer && legal) begin
                m_dly[ch] = int'(dl); m_start[ch] = t + 1;
            end
        end
        if (t < NCYC - 1) t++;
    endtask

    typedef struct {
        logic       rst, vld;
        logic [1:0] ch;
        logic [3:0] dly, din;
        logic       chk, exp_rdy, exp_err;
        logic [3:0] exp_vld;
    } vec_t;

    vec_t tbl [13];
    logic       r_v, v_v;
    logic [1:0] ch_v;
    logic [3:0] dl_v, di_v;
    int         nx;

    initial begin
        rst = 1'b1; cfg_vld = 1'b0; cfg_ch = '0; cfg_dly = '0; din = '0;

        // reset, default fill, ch2->7, ch1->0 (held while not ready), illegal 9
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 4'd0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'hC, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 4'd7, 4'h1, 1'b1, 1'b1, 1'b0, 4'hF};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 4'd0, 4'h2, 1'b1, 1'b0, 1'b0, 4'hB};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 4'd0, 4'h6, 1'b1, 1'b1, 1'b0, 4'hB};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'd9, 4'h0, 1'b1, 1'b0, 1'b0, 4'hB};
        tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'd9, 4'h2, 1'b1, 1'b1, 1'b0, 4'hB};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'hF, 1'b1, 1'b0, 1'b1, 4'hB};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'h4, 1'b1, 1'b1, 1'b0, 4'hB};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'h9, 1'b1, 1'b1, 1'b0, 4'hF};

        for (int i = 0; i < 13; i++) begin
            do_cycle(tbl[i].rst, tbl[i].vld, tbl[i].ch, tbl[i].dly, tbl[i].din);
            if (tbl[i].chk) begin
                check("tbl_rdy", rdy, tbl[i].exp_rdy);
                check("tbl_err", err, tbl[i].exp_err);
                check("tbl_vld", vld, tbl[i].exp_vld);
            end
        end

        // single pulse on ch0 with default delay
        do_cycle(1'b1, 1'b0, 2'd0, 4'd0, 4'h0);
        do_cycle(1'b1, 1'b0, 2'd0, 4'd0, 4'h0);
        for (int k = 0; k <= 20; k++) begin
            do_cycle(1'b0, 1'b0, 2'd0, 4'd0, (k == 10) ? 4'h1 : 4'h0);
            if (k == 13) check("pulse_early", dout[0], 1'b0);
            if (k == 14) check("pulse_at_14", dout[0], 1'b1);
            if (k == 15) check("pulse_late", dout[0], 1'b0);
        end

        // request held high with a new payload every cycle
        nx = 0;
        for (int i = 0; i < 8; i++) begin
            ch_v = 2'(i % 4);
            dl_v = 4'(i + 1);
            do_cycle(1'b0, 1'b1, ch_v, dl_v, 4'($urandom));
            if (rdy) nx++;
        end
        check("b2b_xfers", nx, 4);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 2'd0, 4'd0, 4'($urandom));

        // channel 3 is out of range only for the 3-channel instance
        do_cycle(1'b0, 1'b1, 2'd3, 4'd2, 4'h0);
        do_cycle(1'b0, 1'b0, 2'd0, 4'd0, 4'h0);
        check("err_ch_range_3ch", err3, 1'b1);
        check("err_ch_range_4ch", err, 1'b0);

        // reset in the middle of a fill
        do_cycle(1'b0, 1'b1, 2'd3, 4'd8, 4'hF);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 2'd0, 4'd0, 4'hF);
        do_cycle(1'b1, 1'b1, 2'd0, 4'd1, 4'hF);
        do_cycle(1'b1, 1'b0, 2'd0, 4'd0, 4'hF);
        check("rst_rdy", rdy, 1'b0);
        check("rst_dout", dout, 4'h0);
        check("rst_vld", vld, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            do_cycle(1'b0, 1'b0, 2'd0, 4'd0, 4'hF);
            check("rst_refill_vld", vld, (k == 4) ? 4'hF : 4'h0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r_v  = ($urandom_range(0, 63) == 0);
            v_v  = 1'($urandom_range(0, 1));
            ch_v = 2'($urandom_range(0, 3));
            dl_v = 4'($urandom_range(0, 10));
            di_v = 4'($urandom);
            do_cycle(r_v, v_v, ch_v, dl_v, di_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
